// File: rtl/mem_arbiter_if.sv
// Client request/response and byte-wide RAM port signals of mem_arbiter.
// slave = arbiter side, master = clients and RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 18
);
  logic              i_read_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic [31:0]       i_data_o;
  logic              i_done_o;
  logic              i_wait_o;
  logic              d_read_i;
  logic              d_sign_i;
  logic [2:0]        d_len_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_data_o;
  logic              d_done_o;
  logic              d_wait_o;
  logic              d_write_i;
  logic [ADDR_W-1:0] d_waddr_i;
  logic [7:0]        d_wdata_i;
  logic              d_wwait_o;
  logic              d_writting_o;
  logic              io_full_i;
  logic [7:0]        mem_din_i;
  logic [7:0]        mem_dout_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic              mem_wr_o;

  modport slave (
    input  i_read_i, i_addr_i, d_read_i, d_sign_i, d_len_i, d_addr_i,
           d_write_i, d_waddr_i, d_wdata_i, io_full_i, mem_din_i,
    output i_data_o, i_done_o, i_wait_o, d_data_o, d_done_o, d_wait_o,
           d_wwait_o, d_writting_o, mem_dout_o, mem_a_o, mem_wr_o
  );

  modport master (
    output i_read_i, i_addr_i, d_read_i, d_sign_i, d_len_i, d_addr_i,
           d_write_i, d_waddr_i, d_wdata_i, io_full_i, mem_din_i,
    input  i_data_o, i_done_o, i_wait_o, d_data_o, d_done_o, d_wait_o,
           d_wwait_o, d_writting_o, mem_dout_o, mem_a_o, mem_wr_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter: icache fetch, dcache reads and the dcache write byte stream.
// Build option MEM_ARB_RR_EN: round-robin icache/dcache read arbitration (default: dcache first).
module mem_arbiter #(
  parameter int         ADDR_W = 18,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RD = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_len;
  logic              r_sign;
  logic              r_owner_i;
  logic [2:0]        r_cnt;
  logic [7:0]        r_byte0, r_byte1, r_byte2;
  logic [ADDR_W-1:0] r_mem_a;
  logic [31:0]       r_i_data, r_d_data;

  logic              w_io_stall, w_wr_go, w_accept, w_win_i, w_issue, w_done;
  logic [ADDR_W-1:0] w_mem_a;
  logic [2:0]        w_d_len;
  logic [31:0]       w_asm;

  assign w_io_stall = (bus.d_waddr_i[ADDR_W-1 -: 2] == IO_HI) && bus.io_full_i;
  assign w_d_len    = (bus.d_len_i == 3'd1) ? 3'd1 :
                      (bus.d_len_i == 3'd2) ? 3'd2 : 3'd4;

`ifdef MEM_ARB_RR_EN
  logic r_rr_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_rr_i <= 1'b0;
    else if (w_accept) r_rr_i <= ~w_win_i;
  end

  assign w_win_i = bus.i_read_i && (!bus.d_read_i || r_rr_i);
`else
  assign w_win_i = bus.i_read_i && !bus.d_read_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // rst gates the combinational paths so every output reads 0 during reset
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wr_go     = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rst && bus.d_write_i) begin
          w_wr_go = !w_io_stall;
        end else if (rst && (bus.d_read_i || bus.i_read_i)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        w_issue = (r_cnt < r_len);
        w_done  = (r_cnt == r_len);
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_mem_a = w_wr_go ? bus.d_waddr_i :
                   w_issue ? r_base + ADDR_W'(r_cnt) : r_mem_a;

  // the last byte is never registered; it is taken straight from mem_din_i
  always_comb begin
    case (r_len)
      3'd1:    w_asm = {{24{r_sign & bus.mem_din_i[7]}}, bus.mem_din_i};
      3'd2:    w_asm = {{16{r_sign & bus.mem_din_i[7]}}, bus.mem_din_i, r_byte0};
      default: w_asm = {bus.mem_din_i, r_byte2, r_byte1, r_byte0};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base    <= '0;
      r_len     <= 3'd0;
      r_sign    <= 1'b0;
      r_owner_i <= 1'b0;
      r_cnt     <= 3'd0;
      r_byte0   <= 8'h00;
      r_byte1   <= 8'h00;
      r_byte2   <= 8'h00;
      r_mem_a   <= '0;
      r_i_data  <= 32'h0;
      r_d_data  <= 32'h0;
    end else begin
      r_mem_a <= w_mem_a;
      if (w_accept) begin
        r_base    <= w_win_i ? bus.i_addr_i : bus.d_addr_i;
        r_len     <= w_win_i ? 3'd4 : w_d_len;
        r_sign    <= !w_win_i && bus.d_sign_i;
        r_owner_i <= w_win_i;
        r_cnt     <= 3'd0;
      end else if (r_state == ST_RD) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == ST_RD) begin
        case (r_cnt)
          3'd1:    r_byte0 <= bus.mem_din_i;
          3'd2:    r_byte1 <= bus.mem_din_i;
          3'd3:    r_byte2 <= bus.mem_din_i;
          default: ;
        endcase
      end
      if (w_done && r_owner_i)  r_i_data <= w_asm;
      if (w_done && !r_owner_i) r_d_data <= w_asm;
    end
  end

  assign bus.mem_a_o      = w_mem_a;
  assign bus.mem_wr_o     = w_wr_go;
  assign bus.mem_dout_o   = w_wr_go ? bus.d_wdata_i : 8'h00;
  assign bus.d_writting_o = w_wr_go;
  assign bus.d_wwait_o    = (r_state == ST_RD);
  assign bus.i_wait_o     = rst && ((r_state == ST_RD) || bus.d_write_i || (w_accept && !w_win_i));
  assign bus.d_wait_o     = rst && ((r_state == ST_RD) || bus.d_write_i || (w_accept && w_win_i));
  assign bus.i_done_o     = w_done && r_owner_i;
  assign bus.d_done_o     = w_done && !r_owner_i;
  assign bus.i_data_o     = (w_done && r_owner_i)  ? w_asm : r_i_data;
  assign bus.d_data_o     = (w_done && !r_owner_i) ? w_asm : r_d_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-addressed RAM model plus a read-result model
// computed from little-endian byte sums and sign extension.
module tb_mem_arbiter;
  localparam int ADDR_W = 18;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_edges = 0;
  logic [7:0] ram_w [int];

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W), .IO_HI(2'b11)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input int a);
    if (ram_w.exists(a)) return ram_w[a];
    return 8'(a ^ (a >> 8) ^ 8'h5A);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_wr_o === 1'b1) begin
      ram_w[int'(bus.mem_a_o)] = bus.mem_dout_o;
      wr_edges++;
    end
    bus.mem_din_i <= ram_rd(int'(bus.mem_a_o));
  end

  function automatic int norm_len(input int len_in);
    return (len_in == 1 || len_in == 2) ? len_in : 4;
  endfunction

  function automatic logic [31:0] exp_read(input int addr, input int len_in, input bit sign);
    int n;
    logic [31:0] r;
    n = norm_len(len_in);
    r = 32'h0;
    for (int k = 0; k < n; k++) r = r | (32'(ram_rd((addr + k) & AMASK)) << (8 * k));
    if (sign && n < 4 && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8 * n));
    return r;
  endfunction

  task automatic idle_inputs();
    bus.i_read_i  = 1'b0; bus.i_addr_i  = '0;
    bus.d_read_i  = 1'b0; bus.d_sign_i  = 1'b0; bus.d_len_i = 3'd0; bus.d_addr_i = '0;
    bus.d_write_i = 1'b0; bus.d_waddr_i = '0;   bus.d_wdata_i = 8'h00;
    bus.io_full_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start_read(input bit is_i, input int addr, input int len_in, input bit sign);
    if (is_i) begin
      bus.i_read_i = 1'b1; bus.i_addr_i = ADDR_W'(addr);
    end else begin
      bus.d_read_i = 1'b1; bus.d_addr_i = ADDR_W'(addr);
      bus.d_len_i = 3'(len_in); bus.d_sign_i = sign;
    end
  endtask

  // called during the accept cycle; walks c1..c(N+1) and one hold cycle
  task automatic finish_read(input bit is_i, input int addr, input int len_in, input bit sign,
                             input string name);
    int n, early, bad_a;
    logic [31:0] e_data, got;
    logic [1:0]  dones;
    n = is_i ? 4 : norm_len(len_in);
    e_data = exp_read(addr, is_i ? 4 : len_in, is_i ? 1'b0 : sign);
    early = 0; bad_a = 0;
    got = 32'h0; dones = 2'b00;
    for (int j = 1; j <= n + 1; j++) begin
      @(negedge clk);
      if (j == 1) begin bus.i_read_i = 1'b0; bus.d_read_i = 1'b0; end
      #1;
      if (j <= n) begin
        if (bus.i_done_o !== 1'b0 || bus.d_done_o !== 1'b0) early++;
        if (bus.mem_a_o !== ADDR_W'((addr + j - 1) & AMASK) || bus.mem_wr_o !== 1'b0) bad_a++;
      end else begin
        got   = is_i ? bus.i_data_o : bus.d_data_o;
        dones = {bus.i_done_o, bus.d_done_o};
      end
    end
    n_tests++;
    if (early != 0) begin n_fail++; $display("FAIL %s_early_done: got %0d early pulses, want 0", name, early); end
    n_tests++;
    if (bad_a != 0) begin n_fail++; $display("FAIL %s_addr_seq: got %0d bad address cycles, want 0", name, bad_a); end
    n_tests++;
    if (dones !== (is_i ? 2'b10 : 2'b01)) begin
      n_fail++; $display("FAIL %s_done: got {i,d}=%b want %b", name, dones, is_i ? 2'b10 : 2'b01);
    end
    n_tests++;
    if (got !== e_data) begin n_fail++; $display("FAIL %s_data: got %h want %h", name, got, e_data); end
    @(negedge clk); #1;
    n_tests++;
    if ((is_i ? bus.i_data_o : bus.d_data_o) !== e_data || bus.i_done_o !== 1'b0 || bus.d_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: got data %h done %b%b want %h 00", name,
               is_i ? bus.i_data_o : bus.d_data_o, bus.i_done_o, bus.d_done_o, e_data);
    end
  endtask

  task automatic do_read(input bit is_i, input int addr, input int len_in, input bit sign, input string name);
    @(negedge clk);
    start_read(is_i, addr, len_in, sign);
    #1;
    n_tests++;
    if ((is_i ? bus.i_wait_o : bus.d_wait_o) !== 1'b0) begin
      n_fail++; $display("FAIL %s_wait: got 1 want 0", name);
    end
    finish_read(is_i, addr, len_in, sign, name);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.i_data_o, bus.i_done_o, bus.i_wait_o, bus.d_data_o, bus.d_done_o, bus.d_wait_o,
         bus.d_wwait_o, bus.d_writting_o, bus.mem_dout_o, bus.mem_a_o, bus.mem_wr_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero output, want all 0 (mem_a %h)", bus.mem_a_o);
    end
    bus.d_write_i = 1'b1; bus.d_waddr_i = 18'h00010; bus.d_wdata_i = 8'hC3;
    bus.d_read_i = 1'b1; bus.i_read_i = 1'b1;
    #1;
    n_tests++;
    if ({bus.i_wait_o, bus.d_wait_o, bus.d_writting_o, bus.mem_wr_o, bus.mem_dout_o, bus.mem_a_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_with_req: got wait %b%b wr %b/%b dout %h a %h, want all 0",
               bus.i_wait_o, bus.d_wait_o, bus.d_writting_o, bus.mem_wr_o, bus.mem_dout_o, bus.mem_a_o);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_icache_fetch();
    ram_w[32'h100] = 8'h13; ram_w[32'h101] = 8'h05; ram_w[32'h102] = 8'h00; ram_w[32'h103] = 8'h00;
    do_read(1'b1, 32'h100, 4, 1'b0, "icache_fetch");
    n_tests++;
    if (bus.i_data_o !== 32'h0000_0513) begin n_fail++; $display("FAIL icache_const: got %h want 00000513", bus.i_data_o); end
  endtask

  task automatic test_signed();
    ram_w[32'h1000] = 8'h80;
    do_read(1'b0, 32'h1000, 1, 1'b1, "byte_signed");
    n_tests++;
    if (bus.d_data_o !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_signed_const: got %h want ffffff80", bus.d_data_o); end
    do_read(1'b0, 32'h1000, 1, 1'b0, "byte_unsigned");
    n_tests++;
    if (bus.d_data_o !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_unsigned_const: got %h want 00000080", bus.d_data_o); end
    ram_w[32'h1010] = 8'h34; ram_w[32'h1011] = 8'h92;
    do_read(1'b0, 32'h1010, 2, 1'b1, "half_signed");
    n_tests++;
    if (bus.d_data_o !== 32'hFFFF_9234) begin n_fail++; $display("FAIL half_signed_const: got %h want ffff9234", bus.d_data_o); end
  endtask

  task automatic test_random_reads();
    int addr, len_in;
    bit is_i, sign;
    for (int it = 0; it < 24; it++) begin
      is_i   = 1'($urandom_range(0, 1));
      addr   = (it % 6 == 0) ? AMASK - int'($urandom_range(0, 2)) : int'($urandom) & AMASK;
      len_in = int'($urandom_range(0, 7));
      sign   = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) ram_w[(addr + k) & AMASK] = 8'($urandom);
      do_read(is_i, addr, len_in, sign, "rand_read");
    end
  endtask

  task automatic test_write_stream();
    logic [7:0] wd [4];
    for (int k = 0; k < 4; k++) begin
      wd[k] = 8'($urandom);
      @(negedge clk);
      bus.d_write_i = 1'b1; bus.d_waddr_i = ADDR_W'(32'h200 + k); bus.d_wdata_i = wd[k];
      #1;
      n_tests++;
      if ({bus.mem_wr_o, bus.d_writting_o, bus.mem_a_o, bus.mem_dout_o} !== {2'b11, ADDR_W'(32'h200 + k), wd[k]}) begin
        n_fail++;
        $display("FAIL wstream_byte%0d: got wr %b wrt %b a %h d %h want 1 1 %h %h", k,
                 bus.mem_wr_o, bus.d_writting_o, bus.mem_a_o, bus.mem_dout_o, 32'h200 + k, wd[k]);
      end
    end
    @(negedge clk);
    bus.d_write_i = 1'b0;
    #1;
    n_tests++;
    if (bus.mem_wr_o !== 1'b0) begin n_fail++; $display("FAIL wstream_stop: got mem_wr 1 want 0"); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (ram_rd(32'h200 + k) !== wd[k]) begin
        n_fail++; $display("FAIL wstream_ram%0d: got %h want %h", k, ram_rd(32'h200 + k), wd[k]);
      end
    end
    do_read(1'b0, 32'h200, 4, 1'b0, "wstream_readback");
  endtask

  task automatic test_write_read_conflict();
    @(negedge clk);
    bus.d_write_i = 1'b1; bus.d_waddr_i = 18'h00300; bus.d_wdata_i = 8'hA5;
    start_read(1'b0, 32'h1234, 2, 1'b0);
    #1;
    n_tests++;
    if ({bus.mem_wr_o, bus.d_writting_o, bus.d_wait_o} !== 3'b111) begin
      n_fail++; $display("FAIL conflict_write: got wr/wrt/dwait %b%b%b want 111", bus.mem_wr_o, bus.d_writting_o, bus.d_wait_o);
    end
    @(negedge clk);
    bus.d_write_i = 1'b0;
    #1;
    n_tests++;
    if ({bus.d_wait_o, bus.mem_wr_o} !== 2'b00) begin
      n_fail++; $display("FAIL conflict_accept: got dwait/wr %b%b want 00", bus.d_wait_o, bus.mem_wr_o);
    end
    finish_read(1'b0, 32'h1234, 2, 1'b0, "conflict_read");
  endtask

  task automatic test_io_stall();
    int w0;
    @(negedge clk);
    w0 = wr_edges;
    bus.d_write_i = 1'b1; bus.d_waddr_i = 18'h30000; bus.d_wdata_i = 8'h5C; bus.io_full_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({bus.mem_wr_o, bus.d_writting_o} !== 2'b00) begin
        n_fail++; $display("FAIL io_stall_c%0d: got wr/wrt %b%b want 00", c, bus.mem_wr_o, bus.d_writting_o);
      end
      @(negedge clk);
    end
    bus.io_full_i = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_wr_o, bus.d_writting_o, bus.mem_a_o} !== {2'b11, 18'h30000}) begin
      n_fail++; $display("FAIL io_release: got wr/wrt %b%b a %h want 11 30000", bus.mem_wr_o, bus.d_writting_o, bus.mem_a_o);
    end
    @(negedge clk);
    bus.d_write_i = 1'b0;
    #1;
    n_tests++;
    if (wr_edges - w0 != 1) begin n_fail++; $display("FAIL io_write_count: got %0d writes want 1", wr_edges - w0); end
    n_tests++;
    if (ram_rd(32'h30000) !== 8'h5C) begin n_fail++; $display("FAIL io_write_data: got %h want 5c", ram_rd(32'h30000)); end
  endtask

  task automatic test_arbitration();
    int seq [$];
    int budget;
    logic [31:0] e_d, e_i;
    apply_reset();
    e_d = exp_read(32'h0440, 1, 1'b1);
    e_i = exp_read(32'h0880, 4, 1'b0);
    @(negedge clk);
    start_read(1'b0, 32'h0440, 1, 1'b1);
    start_read(1'b1, 32'h0880, 4, 1'b0);
    budget = 60;
    while (seq.size() < 4 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
      if (bus.d_done_o === 1'b1) begin
        seq.push_back(0);
        n_tests++;
        if (bus.d_data_o !== e_d) begin n_fail++; $display("FAIL arb_d_data: got %h want %h", bus.d_data_o, e_d); end
      end
      if (bus.i_done_o === 1'b1) begin
        seq.push_back(1);
        n_tests++;
        if (bus.i_data_o !== e_i) begin n_fail++; $display("FAIL arb_i_data: got %h want %h", bus.i_data_o, e_i); end
      end
    end
    bus.d_read_i = 1'b0; bus.i_read_i = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (seq.size() < 4) begin
      n_fail++; $display("FAIL arb_timeout: got %0d grants want 4", seq.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
        if (seq[g] != (g % 2)) begin n_fail++; $display("FAIL arb_order%0d: got %0d want %0d (0=d,1=i)", g, seq[g], g % 2); end
`else
        if (seq[g] != 0) begin n_fail++; $display("FAIL arb_order%0d: got %0d want 0 (0=d,1=i)", g, seq[g]); end
`endif
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int pulses;
    @(negedge clk);
    start_read(1'b1, 32'h2220, 4, 1'b0);
    @(negedge clk);
    bus.i_read_i = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.i_data_o, bus.i_done_o, bus.i_wait_o, bus.d_data_o, bus.d_done_o, bus.d_wait_o,
         bus.d_wwait_o, bus.d_writting_o, bus.mem_dout_o, bus.mem_a_o, bus.mem_wr_o} !== '0) begin
      n_fail++; $display("FAIL midread_reset_outputs: got nonzero (mem_a %h i_data %h) want all 0", bus.mem_a_o, bus.i_data_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (bus.i_done_o !== 1'b0 || bus.d_done_o !== 1'b0) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL midread_no_done: got %0d pulses want 0", pulses); end
    do_read(1'b1, 32'h2220, 4, 1'b0, "post_reset_read");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_icache_fetch();
    test_signed();
    test_random_reads();
    test_write_stream();
    test_write_read_conflict();
    test_io_stall();
    test_arbitration();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide, synchronous-read external RAM/IO port and shares it between three clients: icache line/word fetch, dcache reads, dcache write-buffer byte stream.
- Serializes multi-byte reads into per-byte RAM cycles and reassembles little-endian results with optional sign extension.
- Grants dcache write bytes one per cycle, and back-pressures IO writes while the host IO buffer is full.

Parameters:
ADDR_W, 18, width of all byte addresses
IO_HI, 2'b11, value of addr[ADDR_W-1:ADDR_W-2] selecting the IO region

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_read_i  in  1  icache read request (always 4 bytes)
i_addr_i  in  ADDR_W  icache read byte address
i_data_o  out  32  icache read data
i_done_o  out  1  icache read complete, 1-cycle pulse
i_wait_o  out  1  icache request cannot be accepted this cycle
d_read_i  in  1  dcache read request
d_sign_i  in  1  sign-extend result
d_len_i  in  3  byte count: 1, 2 or 4
d_addr_i  in  ADDR_W  dcache read byte address
d_data_o  out  32  dcache read data
d_done_o  out  1  dcache read complete, 1-cycle pulse
d_wait_o  out  1  dcache read cannot be accepted this cycle
d_write_i  in  1  dcache write-buffer byte valid
d_waddr_i  in  ADDR_W  write byte address
d_wdata_i  in  8  write byte
d_wwait_o  out  1  write port busy (a read is in flight)
d_writting_o  out  1  presented byte written this cycle
io_full_i  in  1  host IO buffer full
mem_din_i  in  8  RAM read byte; valid the cycle after its address
mem_dout_o  out  8  RAM write byte
mem_a_o  out  ADDR_W  RAM address
mem_wr_o  out  1  RAM write strobe

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, all captured bytes are 0, and the round-robin pointer is set to dcache.
  - A read in flight at reset is abandoned; no done pulse follows.
- States:
  - IDLE: no read in flight.
  - RD: issuing and collecting bytes for a read.
- Write stream:
  - Serviced only in IDLE and only while no read is accepted that cycle.
  - When d_write_i=1 and the byte is not stalled, in the same cycle: mem_wr_o=1, mem_a_o=d_waddr_i, mem_dout_o=d_wdata_i, d_writting_o=1 (combinational).
  - Stall condition: address in the IO region and io_full_i=1. While stalled, d_writting_o=0 and mem_wr_o=0.
  - d_wwait_o=1 whenever state is RD.
- Read acceptance (IDLE only):
  - A request present while d_write_i=1 is not accepted; the write has priority.
  - Otherwise the winner is chosen between d_read_i and i_read_i (see Optional Feature).
  - The winner's address, length (icache uses 4) and sign are latched at the edge and the state moves to RD.
  - i_wait_o / d_wait_o = 1 when state is RD, or when d_write_i=1, or when the other client wins this cycle.
- RD timing (N = length, accept cycle = c0):
  - Cycles c1..cN: mem_a_o = base+k for k=0..N-1, mem_wr_o=0.
  - Byte k arrives on mem_din_i in cycle c(k+2) and is captured at the end of that cycle.
  - In cycle c(N+1): done pulse to the owner; data is assembled combinationally from the captured bytes plus mem_din_i.
  - State returns to IDLE at the end of c(N+1), so the next grant is possible in c(N+1)'s following cycle.
  - Total latency from acceptance is N+1 cycles.
- Each address is issued exactly once; IO reads are never re-issued or speculated.
- Data assembly:
  - Little-endian: byte k maps to bits 8k+7:8k.
  - For len 1/2 with sign=1, bits above 7/15 replicate bit 7/15; otherwise they are zero-filled.
  - d_len_i values other than 1 or 2 are treated as 4.
- Address arithmetic: base+k wraps modulo 2^ADDR_W.
- Outputs outside a done cycle: i_data_o/d_data_o hold their last value; done outputs are 0.
- Idle RAM port: mem_a_o holds its last value.

Optional Feature:
- MEM_ARB_RR_EN
  - Defined: icache and dcache reads arbitrate round-robin. After a grant the pointer moves to the other client. When both request in IDLE, the pointer's client wins.
  - Undefined: dcache reads have fixed priority over icache reads; the pointer logic is absent.

Test Plan:
- Icache read of addr 0x00100 with RAM bytes 0x13,0x05,0x00,0x00: i_done_o pulses exactly 5 cycles after acceptance, i_data_o=0x00000513, and mem_a_o steps 0x100..0x103.
- Signed byte and halfword reads:
  - dcache len=1, sign=1, byte 0x80 -> d_data_o=0xFFFFFF80.
  - Same with sign=0 -> 0x00000080.
  - len=2, sign=1 on bytes 0x34,0x92 -> 0xFFFF9234.
- Write stream of 4 bytes to 0x00200..0x00203 -> one mem_wr_o per cycle, with d_writting_o=1 in each of those 4 cycles.
- Write with d_write_i and d_read_i in the same IDLE cycle -> write granted, d_wait_o=1 that cycle, read accepted the next cycle.
- IO write to 0x30000 with io_full_i=1 for 3 cycles -> mem_wr_o=0 and d_writting_o=0 for those 3 cycles, then exactly one write once io_full_i drops.
- Both reads requesting continuously: with MEM_ARB_RR_EN grants alternate d,i,d,i; without it, dcache is always granted.
- rst asserted mid-read -> outputs 0 immediately, no done pulse, and a fresh read after release completes normally.
